// File: rtl/difficulty_select.sv
// Button-driven difficulty chooser: sync + debounce + edge detect per button,
// then a SELECT/LOCKED FSM stepping a 2-bit level (EASY/HARD/HELL).
module difficulty_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit WRAP            = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       game_over,
  output logic [1:0] difficulty,
  output logic       start,
  output logic       locked
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] EASY = 2'b00;
  localparam logic [1:0] HARD = 2'b01;
  localparam logic [1:0] HELL = 2'b10;

  typedef enum logic [1:0] {
    SELECT = 2'b00,
    LOCKED = 2'b01
  } state_e;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    deb_q;
  logic [2:0]    deb_dly_q;
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    ev;

  assign btn_raw = {btn_confirm, btn_down, btn_up};

  // Counter only advances while the synced level disagrees with the
  // debounced level, and clears on flip, so it never exceeds CNT_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign ev = deb_q & ~deb_dly_q;

  logic       up_ev;
  logic       dn_ev;
  logic       cf_ev;
  logic [1:0] diff_up_d;
  logic [1:0] diff_dn_d;

  assign up_ev = ev[0];
  assign dn_ev = ev[1];
  assign cf_ev = ev[2];

  always_comb begin
    diff_up_d = difficulty + 2'd1;
    if (difficulty == HELL) diff_up_d = WRAP ? EASY : HELL;
    diff_dn_d = difficulty - 2'd1;
    if (difficulty == EASY) diff_dn_d = WRAP ? HELL : EASY;
  end

  state_e state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SELECT;
      difficulty <= EASY;
      start      <= 1'b0;
      locked     <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state_q)
        SELECT: begin
          if (cf_ev) begin
            start   <= 1'b1;
            locked  <= 1'b1;
            state_q <= LOCKED;
          end else if (up_ev && !dn_ev) begin
            difficulty <= diff_up_d;
          end else if (dn_ev && !up_ev) begin
            difficulty <= diff_dn_d;
          end
        end
        LOCKED: begin
          if (game_over) begin
            locked  <= 1'b0;
            state_q <= SELECT;
          end
        end
        default: begin
          state_q <= SELECT;
          locked  <= 1'b0;
        end
      endcase
      if (difficulty == 2'b11) difficulty <= EASY;
    end
  end

endmodule

// File: tb/tb_difficulty_select.sv
// Directed bench for difficulty_select (DEBOUNCE_CYCLES=4); one wrapping
// instance and one saturating instance share clock and reset.
module tb_difficulty_select;

  logic       clk = 1'b0;
  logic       reset;
  logic       up, dn, cf, go;
  logic       s_up, s_dn, s_cf, s_go;
  logic [1:0] diff, s_diff;
  logic       start, locked, s_start, s_locked;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int base;

  always #5 clk = ~clk;

  difficulty_select #(.DEBOUNCE_CYCLES(4), .WRAP(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .btn_up(up), .btn_down(dn), .btn_confirm(cf),
    .game_over(go),
    .difficulty(diff), .start(start), .locked(locked)
  );

  difficulty_select #(.DEBOUNCE_CYCLES(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset),
    .btn_up(s_up), .btn_down(s_dn), .btn_confirm(s_cf),
    .game_over(s_go),
    .difficulty(s_diff), .start(s_start), .locked(s_locked)
  );

  always @(negedge clk) if (start) start_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {up, dn, cf, go} = '0;
    {s_up, s_dn, s_cf, s_go} = '0;
    tick(2);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sat_diff", 32'(s_diff), 0);

    // 1: held from reset release, event lands on edge 7
    reset = 1'b0;
    up = 1'b1;
    tick(6);
    chk("t1_edge6", 32'(diff), 0);
    tick(1);
    chk("t1_edge7", 32'(diff), 1);
    tick(12);
    chk("t1_held", 32'(diff), 1);
    up = 1'b0; tick(8);
    up = 1'b1; tick(8); up = 1'b0; tick(8);
    chk("t1_press2", 32'(diff), 2);
    up = 1'b1; tick(8); up = 1'b0; tick(8);
    chk("t1_wrap", 32'(diff), 0);
    chk("t1_nostart", 32'(start_cnt), 0);

    // 2: short glitches never debounce
    for (int i = 0; i < 5; i++) begin
      up = 1'b1; tick(3);
      up = 1'b0; tick(3);
    end
    tick(8);
    chk("t2_diff", 32'(diff), 0);
    chk("t2_nostart", 32'(start_cnt), 0);

    // 3: saturating instance
    s_dn = 1'b1; tick(8); s_dn = 1'b0; tick(8);
    chk("t3_dn_easy", 32'(s_diff), 0);
    s_up = 1'b1; tick(8); s_up = 1'b0; tick(8);
    chk("t3_up1", 32'(s_diff), 1);
    s_up = 1'b1; tick(8); s_up = 1'b0; tick(8);
    chk("t3_up2", 32'(s_diff), 2);
    s_up = 1'b1; tick(8); s_up = 1'b0; tick(8);
    chk("t3_up3_sat", 32'(s_diff), 2);

    // 4: reach HELL, simultaneous up+down, confirm and lock
    dn = 1'b1; tick(8); dn = 1'b0; tick(8);
    chk("t4_dn_wrap", 32'(diff), 2);
    up = 1'b1; dn = 1'b1; tick(8);
    up = 1'b0; dn = 1'b0; tick(8);
    chk("t4_updn", 32'(diff), 2);
    base = start_cnt;
    cf = 1'b1;
    tick(6);
    chk("t4_pre_start", 32'(start), 0);
    chk("t4_pre_locked", 32'(locked), 0);
    tick(1);
    chk("t4_start", 32'(start), 1);
    chk("t4_locked", 32'(locked), 1);
    tick(1);
    chk("t4_start_drop", 32'(start), 0);
    cf = 1'b0; tick(8);
    up = 1'b1; tick(8); up = 1'b0; tick(8);
    dn = 1'b1; tick(8); dn = 1'b0; tick(8);
    cf = 1'b1; tick(8); cf = 1'b0; tick(8);
    chk("t4_frozen", 32'(diff), 2);
    chk("t4_still_locked", 32'(locked), 1);
    chk("t4_one_start", 32'(start_cnt - base), 1);

    // 5: game_over releases lock; ignored in SELECT
    go = 1'b1; tick(1); go = 1'b0;
    chk("t5_unlock", 32'(locked), 0);
    up = 1'b1; tick(8); up = 1'b0; tick(8);
    chk("t5_wrap", 32'(diff), 0);
    go = 1'b1; tick(1); go = 1'b0;
    tick(1);
    chk("t5_go_sel_diff", 32'(diff), 0);
    chk("t5_go_sel_lock", 32'(locked), 0);
    chk("t5_go_sel_start", 32'(start_cnt - base), 1);

    // 6: reset mid-debounce, then held button is a fresh press
    up = 1'b1; tick(8); up = 1'b0; tick(8);
    chk("t6_pre", 32'(diff), 1);
    up = 1'b1; tick(4);
    reset = 1'b1; tick(1);
    chk("t6_rst_diff", 32'(diff), 0);
    chk("t6_rst_lock", 32'(locked), 0);
    chk("t6_rst_start", 32'(start), 0);
    reset = 1'b0;
    tick(6);
    chk("t6_edge6", 32'(diff), 0);
    tick(1);
    chk("t6_edge7", 32'(diff), 1);
    up = 1'b0; tick(8);
    cf = 1'b1; tick(8); cf = 1'b0; tick(8);
    chk("t6_locked", 32'(locked), 1);
    reset = 1'b1; tick(1);
    chk("t6_lrst_diff", 32'(diff), 0);
    chk("t6_lrst_lock", 32'(locked), 0);
    chk("t6_lrst_start", 32'(start), 0);
    reset = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
